// File: rtl/button_conditioner.sv
// Button conditioner: per-button synchroniser, debounce, press pulse and
// optional auto-repeat, plus a single priority-arbitrated key event per cycle.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       button_up_in,
  input  logic       button_down_in,
  input  logic       button_left_in,
  input  logic       button_right_in,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       key_valid,
  output logic [1:0] key_code
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} rep_state_e;

  logic [3:0] raw;
  logic [1:0] code_d;

  assign raw = {button_right_in, button_left_in, button_down_in, button_up_in}
             ^ {4{ACTIVE_LOW}};

  for (genvar i = 0; i < 4; i++) begin : g_chan
    logic          sync1_q, sync2_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    logic          accept, press, fall;
    rep_state_e    state_q, state_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          repeat_fire;
    logic          pulse_q;

    // Two-flop synchroniser for the asynchronous raw input
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw[i];
        sync2_q <= sync1_q;
      end
    end

    // Debounce: accept the synchronised level after DEBOUNCE_CYCLES steady cycles
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      accept   = 1'b0;
      if (sync2_q != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          accept  = 1'b1;
          level_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
    end

    assign press = accept & sync2_q;
    assign fall  = accept & ~sync2_q;

    // Debounce counter and accepted level
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        db_cnt_q <= '0;
        level_q  <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
      end
    end

    // Repeat FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        state_q   <= StIdle;
        rep_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        rep_cnt_q <= rep_cnt_d;
      end
    end

    // Repeat FSM next state; an accepted release overrides everything
    always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      case (state_q)
        StIdle: begin
          if (press && REPEAT_EN) begin
            state_d   = StHold;
            rep_cnt_d = '0;
          end
        end
        StHold: begin
          if (rep_cnt_q == HOLD_LAST) begin
            state_d   = StRepeat;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
        StRepeat: begin
          if (rep_cnt_q == REP_LAST) rep_cnt_d = '0;
          else                       rep_cnt_d = rep_cnt_q + RW'(1);
        end
        default: begin
          state_d   = StIdle;
          rep_cnt_d = '0;
        end
      endcase
      if (fall) begin
        state_d   = StIdle;
        rep_cnt_d = '0;
      end
    end

    // Repeat FSM output: fire at the end of each hold/repeat interval
    always_comb begin
      repeat_fire = 1'b0;
      if (!fall) begin
        if (state_q == StHold && rep_cnt_q == HOLD_LAST)       repeat_fire = 1'b1;
        else if (state_q == StRepeat && rep_cnt_q == REP_LAST) repeat_fire = 1'b1;
      end
    end

    // Registered press/repeat pulse, aligned with the level rising
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) pulse_q <= 1'b0;
      else         pulse_q <= press | repeat_fire;
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
  end

  // Lowest set pulse bit wins; hold the last code when nothing pulses
  always_comb begin
    code_d = key_code;
    for (int i = 3; i >= 0; i--) begin
      if (btn_pulse[i]) code_d = 2'(i);
    end
  end

  // Arbitrated key event, one cycle behind btn_pulse
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_valid <= 1'b0;
      key_code  <= 2'd0;
    end else begin
      key_valid <= |btn_pulse;
      key_code  <= code_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a timing model
// expressed in edge counts (press time, hold/repeat arithmetic).
module tb_button_conditioner;
  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] raw = 4'b0000;   // bit0 up, bit1 down, bit2 left, bit3 right
  logic [3:0] raw_n;
  logic [3:0] btn_level, btn_pulse, al_level, al_pulse;
  logic       key_valid, al_valid;
  logic [1:0] key_code, al_code;

  int errors = 0;
  int checks = 0;

  assign raw_n = ~raw;

  always #5 sys_clk = ~sys_clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .button_up_in(raw[0]), .button_down_in(raw[1]),
    .button_left_in(raw[2]), .button_right_in(raw[3]),
    .btn_level(btn_level), .btn_pulse(btn_pulse),
    .key_valid(key_valid), .key_code(key_code)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .button_up_in(raw_n[0]), .button_down_in(raw_n[1]),
    .button_left_in(raw_n[2]), .button_right_in(raw_n[3]),
    .btn_level(al_level), .btn_pulse(al_pulse),
    .key_valid(al_valid), .key_code(al_code)
  );

  // Reference model: sampled-input history, steady-run length, press time.
  logic [3:0] m_sh1, m_sh2, m_level, m_pulse;
  logic       m_kv;
  logic [1:0] m_kc;
  int         m_run[4];
  int         m_press[4];
  int         m_t;

  task automatic model_reset();
    m_sh1 = '0; m_sh2 = '0; m_level = '0; m_pulse = '0; m_kv = 1'b0; m_kc = 2'd0; m_t = 0;
    for (int c = 0; c < 4; c++) begin
      m_run[c] = 0;
      m_press[c] = -1;
    end
  endtask

  // Advance the model by one rising edge using the inputs about to be sampled
  task automatic model_step();
    logic [3:0] np, nl;
    int e;
    np = '0;
    nl = m_level;
    for (int c = 0; c < 4; c++) begin
      if (m_sh2[c] != m_level[c]) m_run[c]++;
      else                        m_run[c] = 0;
      if (m_run[c] == DB) begin
        m_run[c] = 0;
        nl[c] = m_sh2[c];
        if (m_sh2[c]) begin
          np[c] = 1'b1;
          m_press[c] = m_t;
        end else begin
          m_press[c] = -1;
        end
      end else if (m_level[c] && m_press[c] >= 0) begin
        e = m_t - m_press[c];
        if (e >= HOLD && (e - HOLD) % REP == 0) np[c] = 1'b1;
      end
    end
    m_kv = |m_pulse;
    for (int c = 3; c >= 0; c--) begin
      if (m_pulse[c]) m_kc = 2'(c);
    end
    m_pulse = np;
    m_level = nl;
    m_sh2 = m_sh1;
    m_sh1 = raw;
    m_t++;
  endtask

  function automatic logic [10:0] model_out();
    return {m_level, m_pulse, m_kv, m_kc};
  endfunction

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    int first, kv_at;
    raw = 4'b0001;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if ({btn_level, btn_pulse, key_valid, key_code} !== model_out()) begin
        errors++;
        $display("FAIL reset_pre cycle %0d: got=%h want=%h", n,
                 {btn_level, btn_pulse, key_valid, key_code}, model_out());
      end
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_pulse, key_valid, key_code} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async_main: got=%h want=0", {btn_level, btn_pulse, key_valid, key_code});
    end
    checks++;
    if ({al_level, al_pulse, al_valid, al_code} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async_al: got=%h want=0", {al_level, al_pulse, al_valid, al_code});
    end
    model_reset();
    #2 sys_rst = 1'b0;
    first = -1;
    kv_at = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if ({btn_level, btn_pulse, key_valid, key_code} !== model_out()) begin
        errors++;
        $display("FAIL reset_post cycle %0d: got=%h want=%h", n,
                 {btn_level, btn_pulse, key_valid, key_code}, model_out());
      end
      if (btn_pulse[0] && first < 0) first = n;
      if (key_valid && kv_at < 0) begin
        kv_at = n;
        checks++;
        if (key_code !== 2'd0) begin
          errors++;
          $display("FAIL reset_key_code: got=%0d want=0", key_code);
        end
      end
    end
    // First edge after release samples the held button; pulse follows 1+DB edges later
    checks++;
    if (first != 2 + DB) begin
      errors++;
      $display("FAIL reset_pulse_edge: got=%0d want=%0d", first, 2 + DB);
    end
    checks++;
    if (kv_at != 3 + DB) begin
      errors++;
      $display("FAIL reset_key_edge: got=%0d want=%0d", kv_at, 3 + DB);
    end
    raw = 4'b0000;
    settle(25);
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 20; r++) begin
      for (int p = 0; p < 4; p++) begin
        raw[1] = (p != 3);
        tick();
        checks++;
        if (btn_level[1] !== 1'b0 || btn_pulse !== 4'b0 || key_valid !== 1'b0) begin
          errors++;
          $display("FAIL bounce r%0d p%0d: got lvl=%b pulse=%b kv=%b want lvl=0 pulse=0 kv=0",
                   r, p, btn_level[1], btn_pulse, key_valid);
        end
        checks++;
        if ({btn_level, btn_pulse, key_valid, key_code} !== model_out()) begin
          errors++;
          $display("FAIL bounce_model r%0d p%0d: got=%h want=%h", r, p,
                   {btn_level, btn_pulse, key_valid, key_code}, model_out());
        end
      end
    end
    raw = 4'b0000;
    settle(10);
  endtask

  task automatic test_clean_press();
    int rise, fall, pcount, pedge;
    rise = -1; fall = -1; pcount = 0; pedge = -1;
    for (int n = 1; n <= 25; n++) begin
      raw[2] = (n <= 8);
      tick();
      checks++;
      if ({btn_level, btn_pulse, key_valid, key_code} !== model_out()) begin
        errors++;
        $display("FAIL clean_model cycle %0d: got=%h want=%h", n,
                 {btn_level, btn_pulse, key_valid, key_code}, model_out());
      end
      if (btn_level[2] && rise < 0) rise = n;
      if (rise >= 0 && !btn_level[2] && fall < 0) fall = n;
      if (btn_pulse[2]) begin
        pcount++;
        if (pedge < 0) pedge = n;
      end
    end
    checks++;
    if (rise != 6 || fall != 14) begin
      errors++;
      $display("FAIL clean_level_window: got rise=%0d fall=%0d want rise=6 fall=14", rise, fall);
    end
    checks++;
    if (pcount != 1 || pedge != 6) begin
      errors++;
      $display("FAIL clean_pulse: got count=%0d edge=%0d want count=1 edge=6", pcount, pedge);
    end
    settle(5);
  endtask

  task automatic test_hold_repeat();
    int pe[$];
    int want[5] = '{6, 16, 21, 26, 31};
    int kvn;
    kvn = 0;
    for (int n = 1; n <= 45; n++) begin
      raw[3] = (n <= 30);
      tick();
      checks++;
      if ({btn_level, btn_pulse, key_valid, key_code} !== model_out()) begin
        errors++;
        $display("FAIL hold_model cycle %0d: got=%h want=%h", n,
                 {btn_level, btn_pulse, key_valid, key_code}, model_out());
      end
      if (btn_pulse[3]) pe.push_back(n);
      if (key_valid) begin
        kvn++;
        checks++;
        if (key_code !== 2'd3) begin
          errors++;
          $display("FAIL hold_key_code cycle %0d: got=%0d want=3", n, key_code);
        end
      end
    end
    checks++;
    if (pe.size() != 5 || kvn != 5) begin
      errors++;
      $display("FAIL hold_count: got pulses=%0d keys=%0d want 5 and 5", pe.size(), kvn);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pe[i] != want[i]) begin
          errors++;
          $display("FAIL hold_pulse_edge %0d: got=%0d want=%0d", i, pe[i], want[i]);
        end
      end
    end
    settle(5);
  endtask

  task automatic test_simultaneous();
    int pn, kvn, kv_at;
    logic [3:0] pat;
    logic [1:0] code;
    pn = -1; kvn = 0; kv_at = -1; pat = '0; code = 2'd3;
    for (int n = 1; n <= 20; n++) begin
      raw = (n <= 8) ? 4'b1001 : 4'b0000;
      tick();
      checks++;
      if ({btn_level, btn_pulse, key_valid, key_code} !== model_out()) begin
        errors++;
        $display("FAIL simul_model cycle %0d: got=%h want=%h", n,
                 {btn_level, btn_pulse, key_valid, key_code}, model_out());
      end
      if (btn_pulse != 4'b0 && pn < 0) begin
        pn = n;
        pat = btn_pulse;
      end
      if (key_valid) begin
        kvn++;
        if (kv_at < 0) begin
          kv_at = n;
          code = key_code;
        end
      end
    end
    checks++;
    if (pat !== 4'b1001 || pn != 6) begin
      errors++;
      $display("FAIL simul_pulse: got pattern=%b edge=%0d want 1001 edge 6", pat, pn);
    end
    checks++;
    if (kvn != 1 || kv_at != 7 || code !== 2'd0) begin
      errors++;
      $display("FAIL simul_key: got n=%0d edge=%0d code=%0d want n=1 edge=7 code=0",
               kvn, kv_at, code);
    end
    settle(8);
  endtask

  task automatic test_active_low();
    int rise, fall, pcount;
    rise = -1; fall = -1; pcount = 0;
    raw = 4'b0000;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (al_pulse !== 4'b0 || al_valid !== 1'b0 || al_level !== 4'b0) begin
        errors++;
        $display("FAIL al_idle cycle %0d: got lvl=%b pulse=%b kv=%b want all 0",
                 n, al_level, al_pulse, al_valid);
      end
    end
    for (int n = 1; n <= 25; n++) begin
      raw[2] = (n <= 8);
      tick();
      checks++;
      if ({al_level, al_pulse, al_valid, al_code} !== model_out()) begin
        errors++;
        $display("FAIL al_model cycle %0d: got=%h want=%h", n,
                 {al_level, al_pulse, al_valid, al_code}, model_out());
      end
      if (al_level[2] && rise < 0) rise = n;
      if (rise >= 0 && !al_level[2] && fall < 0) fall = n;
      if (al_pulse[2]) pcount++;
    end
    checks++;
    if (rise != 6 || fall != 14 || pcount != 1) begin
      errors++;
      $display("FAIL al_press: got rise=%0d fall=%0d pulses=%0d want 6 14 1", rise, fall, pcount);
    end
    settle(5);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1200; n++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 13) == 0) raw[c] = ~raw[c];
      end
      tick();
      checks++;
      if ({btn_level, btn_pulse, key_valid, key_code} !== model_out()) begin
        errors++;
        $display("FAIL random_main cycle %0d: got=%h want=%h", n,
                 {btn_level, btn_pulse, key_valid, key_code}, model_out());
      end
      checks++;
      if ({al_level, al_pulse, al_valid, al_code} !== model_out()) begin
        errors++;
        $display("FAIL random_al cycle %0d: got=%h want=%h", n,
                 {al_level, al_pulse, al_valid, al_code}, model_out());
      end
    end
  endtask

  initial begin
    model_reset();
    #12 sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    model_reset();
    test_reset();
    test_bounce();
    test_clean_press();
    test_hold_repeat();
    test_simultaneous();
    test_active_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits directly upstream of the menu FSM, between the four raw board buttons (up, down, left, right/confirm) and the FSM's button inputs.
- Synchronises each button, debounces it, and emits one-cycle press pulses, with optional auto-repeat while a button is held.
- Also produces a single arbitrated key event per cycle (valid + 2-bit code), so the FSM sees at most one key per clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (10 ms at 100 MHz); legal minimum 2.
- HOLD_CYCLES, 50000000, cycles from the press pulse to the first auto-repeat pulse.
- REPEAT_CYCLES, 10000000, cycles between subsequent auto-repeat pulses.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives exactly one pulse per debounced press.
- ACTIVE_LOW, 0, 1 inverts all raw button inputs before synchronisation.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  asynchronous active-high reset.
- button_up_in  input  1  raw up button, asynchronous.
- button_down_in  input  1  raw down button, asynchronous.
- button_left_in  input  1  raw left button, asynchronous.
- button_right_in  input  1  raw right/confirm button, asynchronous.
- btn_level  output  4  debounced levels; bit0 = up, bit1 = down, bit2 = left, bit3 = right.
- btn_pulse  output  4  one-cycle press and repeat pulses, same bit order.
- key_valid  output  1  one-cycle arbitrated key event.
- key_code  output  2  arbitrated key: 0 = up, 1 = down, 2 = left, 3 = right; meaningful only when key_valid = 1.

Behaviour:
- Reset (asynchronous, active-high sys_rst):
  - Clears all synchroniser flops, debounce counters, repeat counters, btn_level, btn_pulse, key_valid and key_code to 0.
  - Reset mid-press discards any partial count. A button still held after reset release is treated as a new press and pulses after the normal latency.
- Synchroniser: two flops per channel; the second flop output is s.
- Debounce (per channel, counter width $clog2(DEBOUNCE_CYCLES)):
  - If s == btn_level, the counter is cleared to 0.
  - If s != btn_level and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s != btn_level and counter == DEBOUNCE_CYCLES-1, btn_level <= s and the counter is cleared.
  - Any glitch back to btn_level before acceptance restarts the count from 0.
- Press latency: with the input held steadily high from sampling edge k, btn_level and btn_pulse both go high after edge k+1+DEBOUNCE_CYCLES. Release is debounced identically and gives no pulse.
- btn_pulse is registered. It is high for exactly one cycle on an accepted 0->1 transition of btn_level, and on each repeat event.
- Auto-repeat (REPEAT_EN = 1), per-channel FSM:
  - IDLE -> HOLD on the press pulse; the repeat counter is cleared.
  - HOLD: counts to HOLD_CYCLES, then emits a pulse and goes to REPEAT with the counter cleared.
  - REPEAT: emits a pulse every REPEAT_CYCLES.
  - Any state -> IDLE in the cycle btn_level falls; no pulse is generated in that cycle.
  - Repeat pulse spacing: first at press + HOLD_CYCLES, then every REPEAT_CYCLES.
  - With REPEAT_EN = 0, the FSM stays in IDLE.
- Arbitration:
  - key_valid is registered one cycle after btn_pulse: key_valid <= |btn_pulse.
  - key_code <= index of the lowest set bit of btn_pulse (priority up > down > left > right).
  - Simultaneous lower-priority pulses are dropped, not queued. btn_pulse still shows all of them.
  - key_code holds its last value while key_valid = 0.
- Channels are fully independent. Simultaneous presses are debounced and repeated independently.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, REPEAT_EN=1, ACTIVE_LOW=0.
- Reset: assert sys_rst asynchronously mid-cycle with up held -> all outputs 0 immediately. Release reset with up still held -> btn_pulse[0] high for 1 cycle 5 edges later, key_valid=1 with key_code=0 one cycle after that.
- Bounce rejection: toggle down as 1,1,1,0 per cycle, repeated 20 times -> btn_level[1] stays 0, no btn_pulse, no key_valid.
- Clean press/release of left, held 8 cycles -> btn_pulse[2] exactly once; btn_level[2] high from press+5 to release+5; no pulse on release.
- Hold right for 30 cycles -> pulses at P, P+10, P+15, P+20, P+25 (P = first pulse); key_code=3 on each key_valid. Release -> no further pulses.
- Simultaneous press of up and right in the same cycle -> btn_pulse=4'b1001 for one cycle; the next cycle gives key_valid=1, key_code=0; right's event is dropped.
- ACTIVE_LOW=1 instance: drive inputs 1 when idle and 0 to press -> same timing as the clean-press scenario; idle high inputs give no pulses.
